pov_update_sched: RTL
=====================

Name: pov_update_sched

Overview:
- Frame-synchronous scheduler that owns the POV block's update timing: the load_if_ready strobe and the i_inc_px / i_inc_py demo overrides.
- Takes a per-frame tick from the video timing generator and two raw demo buttons.
- Debounces the buttons and applies frame-counted auto-repeat.
- Emits exactly one POV load window per accepted frame, so vector updates never occur mid-frame.

Parameters:
LOAD_DELAY, 2, clk cycles between accepted frame tick and the load strobe (0 allowed)
DEBOUNCE_FRAMES, 2, consecutive accepted ticks a button must read high before a press registers (>=1)
REPEAT_DELAY, 16, frames from the first increment to the first auto-repeat increment (>=1)
REPEAT_PERIOD, 4, frames between subsequent auto-repeat increments (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
i_frame_tick  in  1  one-cycle pulse, synchronous to clk, at vblank start
i_freeze  in  1  level; when high, frame ticks are ignored (no loads, no button evaluation, no overrun)
i_btn_px  in  1  raw async demo button, X axis
i_btn_py  in  1  raw async demo button, Y axis
o_load_if_ready  out  1  one-cycle registered load strobe to POV
o_inc_px  out  1  registered; valid only while o_load_if_ready is high
o_inc_py  out  1  registered; valid only while o_load_if_ready is high
o_overrun  out  1  sticky; set when a tick arrives while the scheduler is not IDLE
o_frame_num  out  8  count of accepted ticks, wraps 255->0

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - All outputs 0; FSM in IDLE.
  - Button synchronisers, debounce/repeat counters and pending flags cleared.
  - Reset mid-window aborts: no load strobe is issued on the cycle after reset deasserts.
- Button sync: 2-FF synchroniser per button; the logic uses the 2nd stage (btn_s).
- Accepted tick: i_frame_tick && !i_freeze && state==IDLE.
  - i_frame_tick && !i_freeze && state!=IDLE: tick dropped, o_overrun<=1 (held until reset), no other effect.
- Main FSM: IDLE -> SETTLE -> LOAD -> IDLE.
  - IDLE: on accepted tick -> SETTLE with dly<=LOAD_DELAY; o_frame_num increments; per-axis logic evaluates.
  - SETTLE: if dly==0 -> LOAD, else dly--.
  - LOAD: one cycle; o_load_if_ready=1, o_inc_px=pend_x, o_inc_py=pend_y; pend flags clear; -> IDLE.
  - Tick sampled at edge T gives the strobe high during cycle T+2+LOAD_DELAY (registered; default: 4 cycles after the tick).
  - Outputs are registered, so the strobe and inc levels assert together for the same single cycle.
  - o_inc_* are 0 whenever o_load_if_ready is 0.
- Per-axis FSM (identical for X and Y), evaluated only on accepted ticks:
  - REL: btn_s=1 -> DEB with cnt<=1; if DEBOUNCE_FRAMES==1, go straight to the press action instead.
  - DEB: btn_s=0 -> REL. Else cnt++; when cnt reaches DEBOUNCE_FRAMES -> press action.
  - Press action: pend<=1; -> HOLD with cnt<=REPEAT_DELAY-1.
  - HOLD: btn_s=0 -> REL, no increment. Else if cnt==0 -> pend<=1, cnt<=REPEAT_PERIOD-1, stay in HOLD. Else cnt--.
  - Increment frames for a continuous hold: press frame P, then P+REPEAT_DELAY, then every REPEAT_PERIOD frames after that.
  - Counters are 8 bit; parameter values >255 are illegal.
  - Both axes may assert in the same load window.
- i_freeze:
  - Gates only tick acceptance; an in-flight SETTLE/LOAD completes normally.
  - Pend flags persist across frozen frames and are delivered at the next load.
- Simultaneous tick and reset: reset wins.

Decomposition:
- Shared package (fixed_point_params / helpers include set): FSM state encodings, 8-bit counter width constant, default timing constants.
- One natural sub-module: pov_btn_repeat — sync, debounce and auto-repeat for one axis, instantiated twice.
  - Ports: clk, reset, tick_en, btn_raw, pend_clr, pend.

Test Plan:
- Reset, then a single tick, buttons idle -> o_load_if_ready high exactly 4 cycles after the tick cycle, for 1 cycle, with o_inc_px=o_inc_py=0; o_frame_num=1.
- i_btn_px held high across 40 accepted frames (defaults) -> o_inc_px=1 in the load windows of frames 2, 18, 22, 26, 30, 34, 38; 0 in all other frames.
- i_btn_py high for 1 frame only, then low -> no o_inc_py ever. Held for 2 frames -> exactly one o_inc_py, in frame 2.
- Second tick 2 cycles after the first -> o_overrun=1 and stays 1; only one load strobe; o_frame_num advances by 1.
- i_freeze high for 5 ticks with i_btn_px held -> no strobes, o_frame_num unchanged, o_overrun=0; debounce resumes after unfreeze.
- Reset asserted during SETTLE -> no strobe; next tick after reset produces a normal strobe. o_frame_num wraps 255->0 after 256 ticks.

Source files
------------

// File: rtl/pov_update_sched_pkg.sv
// Shared types and constants for the POV update scheduler and its button channels.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: scheduler/axis state encodings, counter width, default timing constants.
package pov_update_sched_pkg;

    localparam int CNT_W = 8;

    localparam int DEF_LOAD_DELAY      = 2;
    localparam int DEF_DEBOUNCE_FRAMES = 2;
    localparam int DEF_REPEAT_DELAY    = 16;
    localparam int DEF_REPEAT_PERIOD   = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOAD   = 2'd2
    } sched_state_t;

    typedef enum logic [1:0] {
        AX_REL  = 2'd0,
        AX_DEB  = 2'd1,
        AX_HOLD = 2'd2
    } axis_state_t;

    // Narrow an integer parameter to the shared counter width.
    function automatic logic [CNT_W-1:0] to_cnt(input int v);
        return CNT_W'(v);
    endfunction

endpackage

// File: rtl/pov_update_sched_if.sv
// Bundle of frame-tick/button inputs and load-window outputs of the POV update scheduler.
// Latency: n/a (wires only).
// Backpressure: none; all signals are free-running levels or one-cycle pulses.
// master: drives tick/freeze/buttons, observes load window; slave: the scheduler.
interface pov_update_sched_if;
    import pov_update_sched_pkg::*;

    logic             i_frame_tick;
    logic             i_freeze;
    logic             i_btn_px;
    logic             i_btn_py;
    logic             o_load_if_ready;
    logic             o_inc_px;
    logic             o_inc_py;
    logic             o_overrun;
    logic [CNT_W-1:0] o_frame_num;

    modport master (
        output i_frame_tick, i_freeze, i_btn_px, i_btn_py,
        input  o_load_if_ready, o_inc_px, o_inc_py, o_overrun, o_frame_num
    );

    modport slave (
        input  i_frame_tick, i_freeze, i_btn_px, i_btn_py,
        output o_load_if_ready, o_inc_px, o_inc_py, o_overrun, o_frame_num
    );

endinterface

// File: rtl/pov_btn_repeat.sv
// One demo-button channel: 2-FF sync, frame-counted debounce and auto-repeat.
// Latency: pend rises on the clk edge of the accepted tick that completes a press/repeat.
// Backpressure: none; pend holds until pend_clr, repeat events while pending merge.
// Ports: clk, reset (sync, high), tick_en (accepted frame), btn_raw (async), pend_clr, pend.
module pov_btn_repeat
    import pov_update_sched_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_en,
    input  logic btn_raw,
    input  logic pend_clr,
    output logic pend
);

    localparam logic [CNT_W-1:0] DEB_LAST = to_cnt(DEBOUNCE_FRAMES - 1);
    localparam logic [CNT_W-1:0] RD_INIT  = to_cnt(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_INIT  = to_cnt(REPEAT_PERIOD - 1);

    logic             r_sync1;
    logic             r_btn_s;
    axis_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_btn_s <= 1'b0;
            r_state <= AX_REL;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_btn_s <= r_sync1;

            // Clear first so a same-edge set (never expected) still wins.
            if (pend_clr) r_pend <= 1'b0;

            if (tick_en) begin
                case (r_state)
                    AX_REL: begin
                        if (r_btn_s) begin
                            if (DEBOUNCE_FRAMES == 1) begin
                                r_pend  <= 1'b1;
                                r_state <= AX_HOLD;
                                r_cnt   <= RD_INIT;
                            end else begin
                                r_state <= AX_DEB;
                                r_cnt   <= to_cnt(1);
                            end
                        end
                    end
                    AX_DEB: begin
                        if (!r_btn_s) begin
                            r_state <= AX_REL;
                        end else if (r_cnt == DEB_LAST) begin
                            // This frame is the DEBOUNCE_FRAMES-th consecutive high read.
                            r_pend  <= 1'b1;
                            r_state <= AX_HOLD;
                            r_cnt   <= RD_INIT;
                        end else begin
                            r_cnt <= r_cnt + to_cnt(1);
                        end
                    end
                    AX_HOLD: begin
                        if (!r_btn_s) begin
                            r_state <= AX_REL;
                        end else if (r_cnt == '0) begin
                            r_pend <= 1'b1;
                            r_cnt  <= RP_INIT;
                        end else begin
                            r_cnt <= r_cnt - to_cnt(1);
                        end
                    end
                    default: r_state <= AX_REL;
                endcase
            end
        end
    end

    assign pend = r_pend;

endmodule

// File: rtl/pov_update_sched.sv
// Frame-synchronous POV update scheduler: one load window per accepted frame tick.
// Latency: tick sampled at edge T -> o_load_if_ready high in cycle T+2+LOAD_DELAY.
// Backpressure: none; ticks arriving while a window is in flight are dropped and flag o_overrun.
// Ports: clk, reset (sync, high), bus (slave: tick/freeze/buttons in, load/inc/overrun/frame_num out).
module pov_update_sched
    import pov_update_sched_pkg::*;
#(
    parameter int LOAD_DELAY      = DEF_LOAD_DELAY,
    parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic               clk,
    input  logic               reset,
    pov_update_sched_if.slave  bus
);

    localparam logic [CNT_W-1:0] DLY_INIT = to_cnt(LOAD_DELAY);

    sched_state_t     r_state;
    logic [CNT_W-1:0] r_dly;
    logic             r_load;
    logic             r_inc_px;
    logic             r_inc_py;
    logic             r_overrun;
    logic [CNT_W-1:0] r_frame_num;

    logic w_tick_live;
    logic w_accept;
    logic w_pend_clr;
    logic w_pend_x;
    logic w_pend_y;

    // Freeze masks the tick entirely; busy states turn a live tick into an overrun.
    assign w_tick_live = bus.i_frame_tick && !bus.i_freeze;
    assign w_accept    = w_tick_live && (r_state == ST_IDLE);
    assign w_pend_clr  = (r_state == ST_LOAD);

    pov_btn_repeat #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_btn_x (
        .clk      (clk),
        .reset    (reset),
        .tick_en  (w_accept),
        .btn_raw  (bus.i_btn_px),
        .pend_clr (w_pend_clr),
        .pend     (w_pend_x)
    );

    pov_btn_repeat #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_btn_y (
        .clk      (clk),
        .reset    (reset),
        .tick_en  (w_accept),
        .btn_raw  (bus.i_btn_py),
        .pend_clr (w_pend_clr),
        .pend     (w_pend_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_dly       <= '0;
            r_load      <= 1'b0;
            r_inc_px    <= 1'b0;
            r_inc_py    <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_num <= '0;
        end else begin
            r_load   <= 1'b0;
            r_inc_px <= 1'b0;
            r_inc_py <= 1'b0;

            if (w_tick_live && (r_state != ST_IDLE)) r_overrun <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state     <= ST_SETTLE;
                        r_dly       <= DLY_INIT;
                        r_frame_num <= r_frame_num + to_cnt(1);
                    end
                end
                ST_SETTLE: begin
                    if (r_dly == '0) r_state <= ST_LOAD;
                    else             r_dly   <= r_dly - to_cnt(1);
                end
                ST_LOAD: begin
                    // Strobe and inc levels are registered together so they share one cycle.
                    r_load   <= 1'b1;
                    r_inc_px <= w_pend_x;
                    r_inc_py <= w_pend_y;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_load_if_ready = r_load;
    assign bus.o_inc_px        = r_inc_px;
    assign bus.o_inc_py        = r_inc_py;
    assign bus.o_overrun       = r_overrun;
    assign bus.o_frame_num     = r_frame_num;

endmodule
